// File: rtl/data_req_adapter_if.sv
// Pipeline-side memory request handshake bundle for data_req_adapter.
interface data_req_adapter_if #(
  parameter int TAG_W = 5
);
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_wr;
  logic [1:0]       mem_size;
  logic             mem_signed;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [TAG_W-1:0] mem_tag;

  // Pipeline side: presents requests, observes acceptance.
  modport master (
    output mem_valid, mem_wr, mem_size, mem_signed, mem_addr, mem_wdata, mem_tag,
    input  mem_ready
  );

  // Adapter side: consumes requests, signals acceptance.
  modport slave (
    input  mem_valid, mem_wr, mem_size, mem_signed, mem_addr, mem_wdata, mem_tag,
    output mem_ready
  );
endinterface

// File: rtl/data_req_adapter.sv
// Adapts pipeline load/store requests to a lane-based data memory port.
// One held request, one outstanding load; misaligned requests are
// swallowed and reported through a one-cycle addr_err pulse.
module data_req_adapter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_p,
  data_req_adapter_if.slave mem,
  output logic             data_req,
  output logic             data_wr,
  output logic [31:0]      data_addr,
  output logic [3:0]       data_wstrb,
  output logic [31:0]      data_wdata,
  input  logic [31:0]      data_rdata,
  input  logic             data_read_ok,
  input  logic             data_write_full,
  output logic             ld_valid,
  output logic [TAG_W-1:0] ld_tag,
  output logic [31:0]      ld_data,
  output logic             addr_err,
  output logic             addr_err_wr,
  output logic [31:0]      addr_err_addr
);

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate right-aligned store data across all lanes it may occupy.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{w[7:0]}};
      2'd1:    d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Select the addressed lane of returned data and extend it.
  function automatic logic [31:0] load_align(input logic [31:0] rd, input logic [1:0] size,
                                             input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    r = {{24{sgn & b[7]}}, b};
      2'd1:    r = {{16{sgn & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  logic             req_v_r;
  logic             req_wr_r;
  logic [31:0]      req_addr_r;
  logic [3:0]       req_wstrb_r;
  logic [31:0]      req_wdata_r;
  logic [1:0]       req_size_r;
  logic             req_signed_r;
  logic [TAG_W-1:0] req_tag_r;

  logic             ld_busy_r;
  logic [TAG_W-1:0] trk_tag_r;
  logic [1:0]       trk_size_r;
  logic             trk_signed_r;
  logic [1:0]       trk_off_r;

  logic             ld_valid_r;
  logic [TAG_W-1:0] ld_tag_r;
  logic [31:0]      ld_data_r;
  logic             addr_err_r;
  logic             addr_err_wr_r;
  logic [31:0]      addr_err_addr_r;

  logic misalign_s;
  logic store_issue_s;
  logic load_issue_s;
  logic issue_s;
  logic ready_s;
  logic accept_s;
  logic ld_ret_s;

  // Issue/accept decisions for the current cycle.
  always_comb begin
    misalign_s    = 1'b0;
    case (mem.mem_size)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = mem.mem_addr[0];
      2'd2:    misalign_s = (mem.mem_addr[1:0] != 2'b00);
      default: misalign_s = 1'b1;
    endcase
    store_issue_s = req_v_r & req_wr_r & ~data_write_full;
    load_issue_s  = req_v_r & ~req_wr_r & (~ld_busy_r | data_read_ok);
    issue_s       = store_issue_s | load_issue_s;
    ready_s       = ~req_v_r | issue_s;
    accept_s      = mem.mem_valid & ready_s;
    ld_ret_s      = data_read_ok & ld_busy_r;
  end

  assign mem.mem_ready = ready_s;

  // Request register: load on aligned accept, drop on issue.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      req_v_r      <= 1'b0;
      req_wr_r     <= 1'b0;
      req_addr_r   <= 32'h0000_0000;
      req_wstrb_r  <= 4'b0000;
      req_wdata_r  <= 32'h0000_0000;
      req_size_r   <= 2'd0;
      req_signed_r <= 1'b0;
      req_tag_r    <= '0;
    end else if (accept_s && !misalign_s) begin
      req_v_r      <= 1'b1;
      req_wr_r     <= mem.mem_wr;
      req_addr_r   <= mem.mem_addr;
      req_wstrb_r  <= mem.mem_wr ? store_strb(mem.mem_size, mem.mem_addr[1:0]) : 4'b0000;
      req_wdata_r  <= store_data(mem.mem_size, mem.mem_wdata);
      req_size_r   <= mem.mem_size;
      req_signed_r <= mem.mem_signed;
      req_tag_r    <= mem.mem_tag;
    end else if (issue_s) begin
      req_v_r      <= 1'b0;
    end else begin
      req_v_r      <= req_v_r;
    end
  end

  // Load tracker: remembers how to steer the single outstanding load.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      ld_busy_r    <= 1'b0;
      trk_tag_r    <= '0;
      trk_size_r   <= 2'd0;
      trk_signed_r <= 1'b0;
      trk_off_r    <= 2'd0;
    end else if (load_issue_s) begin
      ld_busy_r    <= 1'b1;
      trk_tag_r    <= req_tag_r;
      trk_size_r   <= req_size_r;
      trk_signed_r <= req_signed_r;
      trk_off_r    <= req_addr_r[1:0];
    end else if (ld_ret_s) begin
      ld_busy_r    <= 1'b0;
    end else begin
      ld_busy_r    <= ld_busy_r;
    end
  end

  // Writeback: registered load result using the tracker as it was before this edge.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      ld_valid_r <= 1'b0;
      ld_tag_r   <= '0;
      ld_data_r  <= 32'h0000_0000;
    end else begin
      ld_valid_r <= ld_ret_s;
      if (ld_ret_s) begin
        ld_tag_r  <= trk_tag_r;
        ld_data_r <= load_align(data_rdata, trk_size_r, trk_signed_r, trk_off_r);
      end
    end
  end

  // Misalignment report: one-cycle pulse carrying the offending request.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      addr_err_r      <= 1'b0;
      addr_err_wr_r   <= 1'b0;
      addr_err_addr_r <= 32'h0000_0000;
    end else begin
      addr_err_r <= accept_s & misalign_s;
      if (accept_s && misalign_s) begin
        addr_err_wr_r   <= mem.mem_wr;
        addr_err_addr_r <= mem.mem_addr;
      end
    end
  end

  assign data_req      = req_v_r;
  assign data_wr       = req_wr_r;
  assign data_addr     = req_addr_r;
  assign data_wstrb    = req_wstrb_r;
  assign data_wdata    = req_wdata_r;
  assign ld_valid      = ld_valid_r;
  assign ld_tag        = ld_tag_r;
  assign ld_data       = ld_data_r;
  assign addr_err      = addr_err_r;
  assign addr_err_wr   = addr_err_wr_r;
  assign addr_err_addr = addr_err_addr_r;

endmodule
